spi_byte_engine: RTL and testbench

- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Sits directly downstream of the byte-sequencing FSM in the top-level demo.
- Accepts one byte per start pulse, drives sclk/mosi/cs and captures miso.
- Returns the received byte with a one-cycle done pulse.
- Provides the start/data_in/data_out/done contract that the sequencer's IDLE -> SEND_BYTE -> WAIT_DONE loop relies on.

---
 rtl/spi_byte_engine_if.sv | 23 ++
 rtl/spi_byte_engine.sv | 126 ++++++++++++
 tb/tb_spi_byte_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_engine_if.sv
// Host-side byte contract plus SPI pins; the engine takes the slave modport,
// the sequencer/SPI peripheral side takes the master modport.
interface spi_byte_engine_if;
    logic       start;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       done;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs;

    modport slave (
        input  start, data_in, miso,
        output data_out, done, busy, sclk, mosi, cs
    );

    modport master (
        output start, data_in, miso,
        input  data_out, done, busy, sclk, mosi, cs
    );
endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0 MSB-first single-byte SPI master; done rises 17*CLK_DIV clocks after start is accepted.
// No backpressure: start is taken only in IDLE (busy low), requests while busy are dropped.
module spi_byte_engine #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_byte_engine_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    localparam int unsigned    DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     tx_q, tx_d;
    logic [7:0]     rx_q, rx_d;
    logic [7:0]     dout_q, dout_d;
    logic           sclk_q, sclk_d;
    logic           mosi_q, mosi_d;
    logic           cs_q, cs_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.data_in;
                    rx_d    = '0;
                    cs_d    = 1'b0;
                    mosi_d  = bus.data_in[7];
                    busy_d  = 1'b1;
                    div_d   = '0;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    cnt_d  = cnt_q + 4'd1;
                    // cnt_q holds (sclk edge index - 1): even -> rising edge, odd -> falling edge
                    if (!cnt_q[0]) begin
                        rx_d = {rx_q[6:0], bus.miso};
                    end else if (cnt_q == 4'd15) begin
                        sclk_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs       = cs_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine at CLK_DIV=2 (index 0) and CLK_DIV=1 (index 1).
module tb_spi_byte_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_byte_engine_if if2();
    spi_byte_engine_if if1();

    spi_byte_engine #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    spi_byte_engine #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         acc;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave model for the independent-slave case on the CLK_DIV=2 instance
    logic       loop2 = 1'b1;
    logic [7:0] slv_byte = 8'h00;
    logic [7:0] slv_sh = 8'h00;
    logic       slv_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (if2.cs) slv_sh = slv_byte;
        else if (slv_prev_sclk && !if2.sclk) slv_sh = {slv_sh[6:0], 1'b0};
        slv_prev_sclk = if2.sclk;
    end

    assign if2.miso = loop2 ? if2.mosi : slv_sh[7];
    assign if1.miso = if1.mosi;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    logic       prev_sclk [2];
    logic       prev_done [2];
    int         rises     [2];
    logic [7:0] mosi_sh   [2];
    logic [7:0] last_rx   [2];

    task automatic mon(input int d, input int dv, input logic sclk, input logic mosi,
                       input logic done, input logic busy, input logic cs,
                       input logic [7:0] dout);
        exp_t e;
        if (!rst_n) begin
            prev_sclk[d] = 1'b0;
            prev_done[d] = 1'b0;
            rises[d]     = 0;
            mosi_sh[d]   = 8'h00;
            last_rx[d]   = 8'h00;
            return;
        end
        if (sclk && !prev_sclk[d]) begin
            mosi_sh[d] = {mosi_sh[d][6:0], mosi};
            rises[d]++;
        end
        prev_sclk[d] = sclk;
        if (done) begin
            chk("done_width", int'(prev_done[d]), 0);
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: dut %0d got done, expected none", d);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk("data_out", int'(dout), int'(e.rx));
                chk("latency", cyc - e.acc, 17 * dv);
                chk("mosi_bits", int'(mosi_sh[d]), int'(e.tx));
                chk("sclk_rises", rises[d], 8);
                chk("cs_at_done", int'(cs), 1);
                chk("busy_at_done", int'(busy), 0);
            end
            last_rx[d] = dout;
            rises[d]   = 0;
            mosi_sh[d] = 8'h00;
        end else begin
            chk("data_out_stable", int'(dout), int'(last_rx[d]));
        end
        prev_done[d] = done;
    endtask

    always @(negedge clk) begin
        mon(0, 2, if2.sclk, if2.mosi, if2.done, if2.busy, if2.cs, if2.data_out);
        mon(1, 1, if1.sclk, if1.mosi, if1.done, if1.busy, if1.cs, if1.data_out);
    end

    // Returns 1 ns after the accepting edge (edge 0)
    task automatic start_xfer(input int d, input logic [7:0] tx, input logic [7:0] rx);
        exp_t e;
        if (d == 0) begin if2.start = 1'b1; if2.data_in = tx; end
        else        begin if1.start = 1'b1; if1.data_in = tx; end
        @(posedge clk);
        #1;
        e.tx = tx; e.rx = rx; e.acc = cyc;
        if (d == 0) begin exp_q0.push_back(e); if2.start = 1'b0; if2.data_in = ~tx; end
        else        begin exp_q1.push_back(e); if1.start = 1'b0; if1.data_in = ~tx; end
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: dut %0d got no done in 200 cycles, expected one", d);
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
        end
    endtask

    task automatic chk_idle(input string nm, input logic sclk, input logic cs,
                            input logic mosi, input logic done, input logic busy,
                            input logic [7:0] dout);
        chk(nm, int'({sclk, cs, mosi, done, busy, dout}), int'({5'b01000, 8'h00}));
    endtask

    logic [7:0] seq [4];

    initial begin
        if2.start = 1'b0; if2.data_in = 8'h00;
        if1.start = 1'b0; if1.data_in = 8'h00;
        seq[0] = 8'hA5; seq[1] = 8'h5A; seq[2] = 8'h3C; seq[3] = 8'hC3;

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset_state_d2", if2.sclk, if2.cs, if2.mosi, if2.done, if2.busy, if2.data_out);
        chk_idle("reset_state_d1", if1.sclk, if1.cs, if1.mosi, if1.done, if1.busy, if1.data_out);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            chk_idle("idle_d2", if2.sclk, if2.cs, if2.mosi, if2.done, if2.busy, if2.data_out);
            chk_idle("idle_d1", if1.sclk, if1.cs, if1.mosi, if1.done, if1.busy, if1.data_out);
        end

        // loopback A5, D=2
        start_xfer(0, 8'hA5, 8'hA5);
        chk("edge0_cs", int'(if2.cs), 0);
        chk("edge0_busy", int'(if2.busy), 1);
        chk("edge0_mosi", int'(if2.mosi), 1);
        chk("edge0_sclk", int'(if2.sclk), 0);
        wait_done(0);

        // independent slave returning C3
        loop2 = 1'b0;
        slv_byte = 8'hC3;
        @(negedge clk);
        start_xfer(0, 8'h3C, 8'hC3);
        wait_done(0);
        loop2 = 1'b1;

        // back-to-back sequence
        for (int i = 0; i < 4; i++) begin
            start_xfer(0, seq[i], seq[i]);
            wait_done(0);
        end

        // start during busy must be ignored
        repeat (3) @(negedge clk);
        start_xfer(0, 8'h96, 8'h96);
        repeat (9) @(posedge clk);
        #1;
        if2.start = 1'b1; if2.data_in = 8'hFF;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        wait_done(0);
        repeat (40) @(negedge clk);
        #1;
        chk("busy_after_ignored", int'(if2.busy), 0);

        // reset mid-transfer
        start_xfer(0, 8'h77, 8'h77);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_cs", int'(if2.cs), 1);
        chk("midreset_sclk", int'(if2.sclk), 0);
        chk("midreset_busy", int'(if2.busy), 0);
        void'(exp_q0.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk_idle("post_reset_idle", if2.sclk, if2.cs, if2.mosi, if2.done, if2.busy, if2.data_out);
        start_xfer(0, 8'h81, 8'h81);
        wait_done(0);

        // D=1 loopback
        start_xfer(1, 8'hA5, 8'hA5);
        chk("d1_edge0_cs", int'(if1.cs), 0);
        wait_done(1);
        start_xfer(1, 8'h3C, 8'h3C);
        wait_done(1);

        repeat (10) @(negedge clk);
        #1;
        chk("leftover_d2", exp_q0.size(), 0);
        chk("leftover_d1", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
